// File: rtl/result_collector.sv
// Collects result records into ping-pong RAM banks and hands each
// closed bank to the copy engine with its offset, size and host address.
module result_collector #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [63:0]           base_addr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  flush,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  copy_kick,
    input  logic                  copy_busy,
    output logic [31:0]           copy_offset,
    output logic [31:0]           copy_words,
    output logic [63:0]           copy_memory_addr,
    output logic [31:0]           words_total,
    output logic                  done
);

    localparam int BANK_WORDS = 2**(ADDR_WIDTH-1);
    localparam logic [ADDR_WIDTH-1:0] BANK_FULL = ADDR_WIDTH'(BANK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        KICK,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t state;
    state_t state_nx;

    logic                  up;
    logic                  wb;
    logic                  rb;
    logic                  last_seen;
    logic [1:0]            pend;
    logic [1:0]            pend_set;
    logic [1:0]            pend_clr;
    logic [ADDR_WIDTH-1:0] fill;
    logic [ADDR_WIDTH-1:0] fill_nx;
    logic [ADDR_WIDTH-1:0] bank_cnt [2];
    logic                  accept;
    logic                  close;
    logic                  pop;
    logic                  start_ok;
    logic                  kick_go;

    // A bank is writable only when it is neither queued nor being copied.
    assign s_ready  = up && !pend[wb] && !last_seen;
    assign accept   = s_valid && s_ready;
    assign fill_nx  = fill + ADDR_WIDTH'(accept);
    assign close    = (accept && (fill_nx == BANK_FULL || s_last))
                    || (flush && fill_nx != '0);
    assign pop      = (state == WAIT_LO) && !copy_busy;
    assign start_ok = start && (state == IDLE) && (pend == 2'b00);
    assign kick_go  = (state == IDLE) && (state_nx == KICK);

    assign copy_kick = (state == KICK);
    assign pend_set  = close ? (wb ? 2'b10 : 2'b01) : 2'b00;
    assign pend_clr  = pop ? (rb ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pend[rb] && !copy_busy) state_nx = KICK;
            KICK:    state_nx = WAIT_HI;
            WAIT_HI: if (copy_busy) state_nx = WAIT_LO;
            WAIT_LO: if (!copy_busy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            up    <= 1'b0;
        end else begin
            state <= state_nx;
            up    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb          <= 1'b0;
            fill        <= '0;
            pend        <= 2'b00;
            bank_cnt[0] <= '0;
            bank_cnt[1] <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
        end else begin
            pend   <= (pend | pend_set) & ~pend_clr;
            ram_we <= accept;
            if (accept) begin
                ram_addr <= {wb, fill[ADDR_WIDTH-2:0]};
                ram_din  <= s_data;
            end
            if (close) begin
                bank_cnt[wb] <= fill_nx;
                wb           <= ~wb;
                fill         <= '0;
            end else if (accept) begin
                fill <= fill_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb               <= 1'b0;
            last_seen        <= 1'b0;
            done             <= 1'b0;
            copy_offset      <= '0;
            copy_words       <= '0;
            copy_memory_addr <= '0;
            words_total      <= '0;
        end else begin
            if (start_ok) begin
                copy_memory_addr <= base_addr;
                words_total      <= '0;
                done             <= 1'b0;
                last_seen        <= 1'b0;
            end
            if (accept && s_last)
                last_seen <= 1'b1;
            if (kick_go) begin
                copy_offset <= rb ? 32'(BANK_WORDS) : 32'd0;
                copy_words  <= 32'(bank_cnt[rb]);
            end
            if (pop) begin
                rb               <= ~rb;
                copy_memory_addr <= copy_memory_addr + (64'(copy_words) << 3);
                words_total      <= words_total + copy_words;
                // Done only once nothing is left queued or about to be queued.
                if (last_seen && !pend[!rb] && !close)
                    done <= 1'b1;
            end
        end
    end

endmodule
